// File: rtl/sleep_scheduler_if.sv
// sleep_scheduler_if: groups the scheduler's stimulus inputs and pulse/status outputs.
//   master : drives tick, tired, disturb, action, vital_energy_level;
//            observes sleep_in_signal, wake_up_signal, phase, sleep_debt
//   slave  : the scheduler side (directions mirrored)
interface sleep_scheduler_if;
  logic       tick;
  logic       tired;
  logic       disturb;
  logic [7:0] action;
  logic [1:0] vital_energy_level;
  logic       sleep_in_signal;
  logic       wake_up_signal;
  logic [1:0] phase;
  logic [7:0] sleep_debt;

  modport master (
    output tick, tired, disturb, action, vital_energy_level,
    input  sleep_in_signal, wake_up_signal, phase, sleep_debt
  );

  modport slave (
    input  tick, tired, disturb, action, vital_energy_level,
    output sleep_in_signal, wake_up_signal, phase, sleep_debt
  );
endinterface

// File: rtl/sleep_scheduler.sv
// sleep_scheduler: day/night controller that decides when the creature falls
// asleep and wakes, and issues one-cycle sleep_in/wake_up pulses to the action
// regulator.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   sif (slave)              tick, tired, disturb, action[7:0], vital_energy_level[1:0] in;
//                            sleep_in_signal, wake_up_signal, phase[1:0], sleep_debt[7:0] out
// Optional feature macro: SLEEP_SCHEDULER_DEBT_EN
//   defined   : long awake periods accumulate sleep debt that lengthens the next sleep
//   undefined : sleep_debt is 0 and every sleep requires BASE_SLEEP ticks
module sleep_scheduler #(
  parameter int unsigned DROWSY_TICKS  = 4,
  parameter int unsigned MAX_AWAKE     = 200,
  parameter int unsigned NOMINAL_AWAKE = 120,
  parameter int unsigned MIN_SLEEP     = 16,
  parameter int unsigned BASE_SLEEP    = 32,
  parameter int unsigned MAX_SLEEP     = 255,
  parameter int unsigned GRACE_TICKS   = 8
) (
  input  logic            clk,
  input  logic            rst,
  sleep_scheduler_if.slave sif
);

  localparam logic [2:0] LP_DROWSY    = 3'(DROWSY_TICKS);
  localparam logic [7:0] LP_MAX_AWAKE = 8'(MAX_AWAKE);
  localparam logic [7:0] LP_MIN_SLEEP = 8'(MIN_SLEEP);
  localparam logic [7:0] LP_MAX_SLEEP = 8'(MAX_SLEEP);
  localparam logic [3:0] LP_GRACE     = 4'(GRACE_TICKS);

  typedef enum logic [1:0] {
    PH_AWAKE  = 2'd0,
    PH_DROWSY = 2'd1,
    PH_ASLEEP = 2'd2,
    PH_WAKING = 2'd3
  } phase_e;

  phase_e     r_state,     w_state_nxt;
  logic [7:0] r_awake_cnt, w_awake_cnt_nxt;
  logic [2:0] r_tired_cnt, w_tired_cnt_nxt;
  logic [7:0] r_sleep_cnt, w_sleep_cnt_nxt;
  logic [3:0] r_grace_cnt, w_grace_cnt_nxt;
  logic       r_sleep_in,  w_sleep_in_nxt;
  logic       r_wake_up,   w_wake_up_nxt;

  logic [7:0] w_debt;
  logic [7:0] w_awake_inc;
  logic [2:0] w_tired_inc;
  logic [7:0] w_sleep_inc;
  logic [3:0] w_grace_inc;
  logic [8:0] w_req_sum;
  logic [7:0] w_required;
  logic       w_wake_cond;
  logic [5:0] w_unused_action;

  assign w_unused_action = sif.action[7:2];

  // Saturating increments: counters hold at all-ones instead of wrapping.
  assign w_awake_inc = (r_awake_cnt == 8'hFF) ? r_awake_cnt : r_awake_cnt + 8'd1;
  assign w_tired_inc = (r_tired_cnt == 3'h7)  ? r_tired_cnt : r_tired_cnt + 3'd1;
  assign w_sleep_inc = (r_sleep_cnt == 8'hFF) ? r_sleep_cnt : r_sleep_cnt + 8'd1;
  assign w_grace_inc = (r_grace_cnt == 4'hF)  ? r_grace_cnt : r_grace_cnt + 4'd1;

  // Required sleep length grows with debt, capped at the hard wake limit.
  assign w_req_sum  = 9'(BASE_SLEEP) + {1'b0, w_debt};
  assign w_required = (w_req_sum > 9'(MAX_SLEEP)) ? LP_MAX_SLEEP : w_req_sum[7:0];

  // Wake is only honoured once the minimum sleep has elapsed.
  assign w_wake_cond = (r_sleep_cnt >= LP_MIN_SLEEP) &&
                       (((r_sleep_cnt >= w_required) && (sif.vital_energy_level == 2'd3)) ||
                        sif.disturb ||
                        (r_sleep_cnt == LP_MAX_SLEEP));

  // Next-state, counter and pulse logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_awake_cnt_nxt = r_awake_cnt;
    w_tired_cnt_nxt = r_tired_cnt;
    w_sleep_cnt_nxt = r_sleep_cnt;
    w_grace_cnt_nxt = r_grace_cnt;
    w_sleep_in_nxt  = 1'b0;
    w_wake_up_nxt   = 1'b0;

    case (r_state)
      PH_AWAKE: begin
        if (sif.tick) begin
          w_awake_cnt_nxt = w_awake_inc;
          w_tired_cnt_nxt = sif.tired ? w_tired_inc : 3'd0;
        end
        if ((w_tired_cnt_nxt == LP_DROWSY) || (w_awake_cnt_nxt == LP_MAX_AWAKE)) begin
          w_state_nxt = PH_DROWSY;
        end
      end

      PH_DROWSY: begin
        // Eating is never interrupted; the transition itself is not tick-gated.
        if (!sif.action[1]) begin
          w_sleep_in_nxt  = 1'b1;
          w_state_nxt     = PH_ASLEEP;
          w_sleep_cnt_nxt = 8'd0;
          w_awake_cnt_nxt = 8'd0;
          w_tired_cnt_nxt = 3'd0;
        end
      end

      PH_ASLEEP: begin
        if (sif.tick) begin
          w_sleep_cnt_nxt = w_sleep_inc;
        end
        // Wake has priority over re-commanding SLEEP to an overridden regulator.
        if (w_wake_cond) begin
          w_wake_up_nxt   = 1'b1;
          w_state_nxt     = PH_WAKING;
          w_grace_cnt_nxt = 4'd0;
        end else if (sif.tick && !sif.action[0]) begin
          w_sleep_in_nxt = 1'b1;
        end
      end

      PH_WAKING: begin
        w_tired_cnt_nxt = 3'd0;
        if (sif.tick) begin
          w_grace_cnt_nxt = w_grace_inc;
        end
        if (w_grace_cnt_nxt == LP_GRACE) begin
          w_state_nxt = PH_AWAKE;
        end
      end

      default: begin
        w_state_nxt = PH_AWAKE;
      end
    endcase
  end

  // State, counter and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= PH_AWAKE;
      r_awake_cnt <= 8'd0;
      r_tired_cnt <= 3'd0;
      r_sleep_cnt <= 8'd0;
      r_grace_cnt <= 4'd0;
      r_sleep_in  <= 1'b0;
      r_wake_up   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_awake_cnt <= w_awake_cnt_nxt;
      r_tired_cnt <= w_tired_cnt_nxt;
      r_sleep_cnt <= w_sleep_cnt_nxt;
      r_grace_cnt <= w_grace_cnt_nxt;
      r_sleep_in  <= w_sleep_in_nxt;
      r_wake_up   <= w_wake_up_nxt;
    end
  end

`ifdef SLEEP_SCHEDULER_DEBT_EN
  localparam logic [7:0] LP_NOMINAL = 8'(NOMINAL_AWAKE);

  logic [7:0] r_debt, w_debt_nxt;

  // Debt accrues per tick beyond the nominal awake time and is repaid by time slept.
  always_comb begin
    w_debt_nxt = r_debt;
    if ((r_state == PH_AWAKE) && sif.tick && (r_awake_cnt >= LP_NOMINAL)) begin
      w_debt_nxt = (r_debt == 8'hFF) ? r_debt : r_debt + 8'd1;
    end else if (w_wake_up_nxt) begin
      w_debt_nxt = (r_debt > r_sleep_cnt) ? r_debt - r_sleep_cnt : 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_debt <= 8'd0;
    end else begin
      r_debt <= w_debt_nxt;
    end
  end

  assign w_debt = r_debt;
`else
  logic [7:0] w_unused_nominal;

  assign w_unused_nominal = 8'(NOMINAL_AWAKE);
  assign w_debt           = 8'd0;
`endif

  assign sif.phase           = r_state;
  assign sif.sleep_in_signal = r_sleep_in;
  assign sif.wake_up_signal  = r_wake_up;
  assign sif.sleep_debt      = w_debt;

endmodule

// File: tb/tb_sleep_scheduler.sv
// tb_sleep_scheduler: directed, self-checking bench for sleep_scheduler.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sleep_scheduler;

  logic clk;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  sleep_scheduler_if sif ();

  sleep_scheduler u_dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

`ifdef SLEEP_SCHEDULER_DEBT_EN
  localparam int unsigned EXP_DEBT_199 = 79;
  localparam int unsigned EXP_DEBT_200 = 80;
  localparam int unsigned EXP_REQ3     = 112;
`else
  localparam int unsigned EXP_DEBT_199 = 0;
  localparam int unsigned EXP_DEBT_200 = 0;
  localparam int unsigned EXP_REQ3     = 32;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic tick_once();
    sif.tick = 1'b1;
    @(negedge clk);
    sif.tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_once();
  endtask

  initial begin
    rst                    = 1'b1;
    sif.tick               = 1'b0;
    sif.tired              = 1'b0;
    sif.disturb            = 1'b0;
    sif.action             = 8'h40;
    sif.vital_energy_level = 2'd3;
    repeat (2) @(negedge clk);
    chk("rst_phase",    32'(sif.phase),           32'd0);
    chk("rst_sleep_in", 32'(sif.sleep_in_signal), 32'd0);
    chk("rst_wake_up",  32'(sif.wake_up_signal),  32'd0);
    chk("rst_debt",     32'(sif.sleep_debt),      32'd0);
    rst = 1'b0;

    // Drowsiness from 4 tired ticks, then sleep entry
    sif.tired = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick_once();
      chk("tired_still_awake", 32'(sif.phase), 32'd0);
    end
    tick_once();
    chk("tired_drowsy",       32'(sif.phase),           32'd1);
    chk("tired_no_pulse_yet", 32'(sif.sleep_in_signal), 32'd0);
    step();
    chk("sleep_in_pulse", 32'(sif.sleep_in_signal), 32'd1);
    chk("asleep_phase",   32'(sif.phase),           32'd2);
    sif.action = 8'h01;
    sif.tired  = 1'b0;
    step();
    chk("sleep_in_one_clk", 32'(sif.sleep_in_signal), 32'd0);

    // Disturb ignored before minimum sleep, honoured at 16
    ticks(5);
    sif.disturb = 1'b1;
    step();
    chk("disturb_tick5_ignored", 32'(sif.wake_up_signal), 32'd0);
    sif.disturb = 1'b0;
    ticks(10);
    sif.disturb = 1'b1;
    step();
    chk("disturb_tick15_ignored", 32'(sif.wake_up_signal), 32'd0);
    tick_once();
    chk("disturb_tick16_edge", 32'(sif.wake_up_signal), 32'd0);
    step();
    chk("disturb_wake",          32'(sif.wake_up_signal),  32'd1);
    chk("disturb_waking_phase",  32'(sif.phase),           32'd3);
    chk("disturb_no_sleep_in",   32'(sif.sleep_in_signal), 32'd0);
    sif.disturb = 1'b0;
    step();
    chk("wake_one_clk", 32'(sif.wake_up_signal), 32'd0);

    // Grace period ignores tired, then eating defers sleep
    sif.tired = 1'b1;
    ticks(7);
    chk("grace_7_waking", 32'(sif.phase), 32'd3);
    tick_once();
    chk("grace_8_awake", 32'(sif.phase), 32'd0);
    ticks(3);
    chk("tired_ignored_in_grace", 32'(sif.phase), 32'd0);
    sif.action = 8'h02;
    tick_once();
    chk("eat_drowsy", 32'(sif.phase), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("eat_no_pulse", 32'(sif.sleep_in_signal), 32'd0);
    end
    chk("eat_still_drowsy", 32'(sif.phase), 32'd1);
    sif.action = 8'h40;
    step();
    chk("eat_done_pulse",  32'(sif.sleep_in_signal), 32'd1);
    chk("eat_done_asleep", 32'(sif.phase),           32'd2);
    sif.action = 8'h01;
    sif.tired  = 1'b0;
    step();
    chk("eat_pulse_one_clk", 32'(sif.sleep_in_signal), 32'd0);

    // Energy wake at 32 with no debt
    ticks(31);
    step();
    chk("energy_31_no_wake", 32'(sif.wake_up_signal), 32'd0);
    tick_once();
    chk("energy_tick32_edge", 32'(sif.wake_up_signal), 32'd0);
    step();
    chk("energy_wake_32",  32'(sif.wake_up_signal), 32'd1);
    chk("energy_debt_0",   32'(sif.sleep_debt),     32'd0);
    ticks(8);
    chk("energy_grace_done", 32'(sif.phase), 32'd0);

    // Forced drowsiness after 200 awake ticks, with debt
    ticks(199);
    chk("awake_199_phase", 32'(sif.phase),      32'd0);
    chk("awake_199_debt",  32'(sif.sleep_debt), EXP_DEBT_199);
    tick_once();
    chk("awake_200_drowsy", 32'(sif.phase),      32'd1);
    chk("awake_200_debt",   32'(sif.sleep_debt), EXP_DEBT_200);
    step();
    chk("debt_sleep_in", 32'(sif.sleep_in_signal), 32'd1);
    chk("debt_asleep",   32'(sif.phase),           32'd2);
    ticks(int'(EXP_REQ3) - 1);
    step();
    chk("debt_early_no_wake", 32'(sif.wake_up_signal), 32'd0);
    tick_once();
    step();
    chk("debt_wake",       32'(sif.wake_up_signal), 32'd1);
    chk("debt_repaid",     32'(sif.sleep_debt),     32'd0);
    ticks(8);
    chk("debt_grace_done", 32'(sif.phase), 32'd0);

    // Retry while overridden, then hard cap at 255
    sif.tired  = 1'b1;
    sif.action = 8'h40;
    ticks(4);
    chk("cap_drowsy", 32'(sif.phase), 32'd1);
    step();
    chk("cap_sleep_in", 32'(sif.sleep_in_signal), 32'd1);
    chk("cap_asleep",   32'(sif.phase),           32'd2);
    step();
    chk("no_retry_without_tick", 32'(sif.sleep_in_signal), 32'd0);
    sif.vital_energy_level = 2'd0;
    tick_once();
    chk("retry_first", 32'(sif.sleep_in_signal), 32'd1);
    step();
    chk("retry_one_clk", 32'(sif.sleep_in_signal), 32'd0);
    for (int i = 2; i <= 255; i++) begin
      tick_once();
      chk("retry_pulse", 32'(sif.sleep_in_signal), 32'd1);
      chk("retry_no_wake", 32'(sif.wake_up_signal), 32'd0);
    end
    tick_once();
    chk("cap_wake",         32'(sif.wake_up_signal),  32'd1);
    chk("cap_wake_wins",    32'(sif.sleep_in_signal), 32'd0);
    chk("cap_waking_phase", 32'(sif.phase),           32'd3);
    ticks(7);
    chk("cap_grace_7", 32'(sif.phase), 32'd3);
    tick_once();
    chk("cap_grace_8", 32'(sif.phase), 32'd0);
    ticks(3);
    chk("cap_tired_reset_by_grace", 32'(sif.phase), 32'd0);
    tick_once();
    chk("cap_tired_drowsy", 32'(sif.phase), 32'd1);
    step();
    chk("pre_rst_sleep_in", 32'(sif.sleep_in_signal), 32'd1);
    chk("pre_rst_asleep",   32'(sif.phase),           32'd2);

    // Asynchronous reset mid-ASLEEP, away from any clock edge
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_phase",    32'(sif.phase),           32'd0);
    chk("async_rst_sleep_in", 32'(sif.sleep_in_signal), 32'd0);
    chk("async_rst_wake_up",  32'(sif.wake_up_signal),  32'd0);
    chk("async_rst_debt",     32'(sif.sleep_debt),      32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sleep_scheduler.md
Name: sleep_scheduler

Overview:
- Day/night controller that sequences the action regulator's SLEEP entry and exit.
- Tracks wakefulness on a prescaled time strobe, decides when the creature falls asleep and when it wakes.
- Issues the single-cycle sleep_in_signal / wake_up_signal pulses the action regulator consumes.
- Keeps a saturating sleep-debt counter so long awake periods produce longer sleeps.

Parameters:
- DROWSY_TICKS, 4: consecutive ticks with tired=1 that force drowsiness.
- MAX_AWAKE, 200: awake ticks after which drowsiness is forced regardless of tired.
- NOMINAL_AWAKE, 120: awake ticks beyond which each further tick adds 1 to sleep debt.
- MIN_SLEEP, 16: ticks asleep before any wake condition is honoured.
- BASE_SLEEP, 32: required sleep ticks with zero debt.
- MAX_SLEEP, 255: hard wake limit in ticks (8-bit).
- GRACE_TICKS, 8: ticks after waking during which sleep requests are ignored.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle time strobe; all counters advance only on tick=1
- tired  in  1  tired stimulus (stimuli[13])
- disturb  in  1  external wake request (loud stimulus), level
- action  in  8  current one-hot action from the regulator; bit0=SLEEP, bit1=EAT
- vital_energy_level  in  2  current energy level, 3 = full
- sleep_in_signal  out  1  one-cycle pulse: enter SLEEP
- wake_up_signal  out  1  one-cycle pulse: leave SLEEP (regulator goes IDLE)
- phase  out  2  state: 0 AWAKE, 1 DROWSY, 2 ASLEEP, 3 WAKING
- sleep_debt  out  8  saturating debt counter

Behaviour:
- Reset (async, rst=1): phase=AWAKE; all counters 0; sleep_in_signal=0; wake_up_signal=0; sleep_debt=0.
- All outputs are registered. A pulse is asserted in the cycle after the condition is sampled and lasts exactly one clk.
- Internal counters: awake_cnt (8b), tired_cnt (3b), sleep_cnt (8b), grace_cnt (4b). All saturate, none wrap.
- AWAKE:
  - On tick: awake_cnt++; tired_cnt++ if tired, else tired_cnt cleared.
  - Debt: on tick with awake_cnt >= NOMINAL_AWAKE, sleep_debt++ (saturate at 255).
  - Go to DROWSY when tired_cnt==DROWSY_TICKS or awake_cnt==MAX_AWAKE.
- DROWSY:
  - Wait while action[1]=1 (eating is never interrupted).
  - First cycle with action[1]=0: pulse sleep_in_signal. Next state ASLEEP; sleep_cnt=0, awake_cnt=0, tired_cnt=0.
- ASLEEP:
  - On tick: sleep_cnt++.
  - required = BASE_SLEEP + sleep_debt, saturating at MAX_SLEEP.
  - Wake condition, checked only when sleep_cnt >= MIN_SLEEP: (sleep_cnt >= required and vital_energy_level==3) or disturb=1 or sleep_cnt==MAX_SLEEP.
  - On wake: pulse wake_up_signal; sleep_debt -= sleep_cnt, saturating at 0; go to WAKING with grace_cnt=0.
  - Retry: if action[0]=0 on a tick while ASLEEP (regulator overridden, e.g. apathetic->IDLE), re-pulse sleep_in_signal that cycle. sleep_cnt still advances.
  - If a wake and a retry would coincide, the wake wins.
- WAKING:
  - On tick: grace_cnt++. tired is ignored; tired_cnt is held at 0.
  - grace_cnt==GRACE_TICKS -> AWAKE.
- Simultaneous events: only one pulse per cycle; wake_up_signal and sleep_in_signal are never both 1.
- Reset mid-operation: both pulses drop immediately and the FSM returns to AWAKE. The regulator is not commanded, so a SLEEP action persists until the next wake pulse.
- tick=0: no counter changes. The DROWSY->ASLEEP transition is not tick-gated.

Optional Feature:
- Macro: SLEEP_SCHEDULER_DEBT_EN.
- Defined: sleep debt accumulates and is repaid as described above.
- Undefined: sleep_debt is tied to 0, required = BASE_SLEEP, and the debt logic is removed.

Test Plan:
- Reset: rst=1 mid-ASLEEP -> phase=0, both pulses 0, sleep_debt=0, all within the same cycle (async).
- Drowsiness from tired: tired=1 for 4 ticks, action=0x40 -> phase=1 after 4th tick; sleep_in_signal high one cycle later for exactly 1 clk; phase=2.
- Eating defers sleep: enter DROWSY with action=0x02 held 10 cycles -> no pulse; action=0x40 -> sleep_in_signal next cycle.
- Energy wake: asleep, debt=0, energy=3 throughout -> wake_up_signal on tick 32 (not before 16); disturb=1 at tick 5 -> no wake; disturb=1 at tick 16 -> wake.
- Debt (macro on): tired=0 for 200 ticks -> forced DROWSY, sleep_debt=80; required=112; wake at sleep tick 112; sleep_debt=0 after. Macro off: wake at tick 32, sleep_debt stays 0.
- Retry and cap: action forced to 0x40 while ASLEEP -> sleep_in_signal re-pulses on each tick; energy=0 -> wake_up_signal at tick 255, then 8-tick WAKING with tired=1 ignored.
